// File: rtl/psum_drain_arbiter.sv
// Round-robin drain of per-column psum streams into a single addressed write port.
// Define PSUM_DRAIN_ERR_EN to add the sticky overflow_err output.
`ifndef PSUM_DATA_SIZE
`define PSUM_DATA_SIZE 16
`endif

module psum_drain_arbiter #(
    parameter int NUM_COL  = 7,
    parameter int NUM_FILT = 4,
    parameter int DEPTH    = 55
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_drain,
    input  logic [5:0]                         num_psum,
    input  logic [NUM_COL-1:0]                 col_valid,
    input  logic [NUM_COL*2-1:0]               col_filter_idx,
    input  logic [NUM_COL*`PSUM_DATA_SIZE-1:0] col_psum,
    output logic [NUM_COL-1:0]                 col_ack,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic [10:0]                        wr_addr,
    output logic [`PSUM_DATA_SIZE-1:0]         wr_data,
    output logic                               busy,
    output logic                               done,
    output logic [1:0]                         dbg_state
`ifdef PSUM_DRAIN_ERR_EN
    ,
    output logic                               overflow_err
`endif
);

    localparam int PSUM_W = `PSUM_DATA_SIZE;
    localparam int CW     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int NCNT   = NUM_COL * NUM_FILT;

    // dbg_state encoding is part of the interface: IDLE=0, DRAIN=1, DONE=2.
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [5:0]          num_q, num_d;
    logic [5:0]          cnt_q [NCNT];
    logic [5:0]          cnt_d [NCNT];
    logic                wr_valid_q, wr_valid_d;
    logic [10:0]         wr_addr_q, wr_addr_d;
    logic [PSUM_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef PSUM_DRAIN_ERR_EN
    logic                ovf_q, ovf_d;
`endif

    logic [NUM_COL-1:0]  eligible;
    logic                grant;
    logic [CW-1:0]       grant_col;
    logic                slot_free;
    logic                all_full;

    // wr_valid/wr_ready: a write transfers on a rising edge where both are high;
    // while wr_valid is high and wr_ready low, wr_addr and wr_data hold stable.
    always_comb begin
        int f;
        int idx;
        int gi;
        int gf;
        f          = 0;
        idx        = 0;
        gi         = 0;
        gf         = 0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        col_ack    = '0;
        eligible   = '0;
        grant      = 1'b0;
        grant_col  = '0;
        all_full   = 1'b1;
        slot_free  = !wr_valid_q || wr_ready;
`ifdef PSUM_DRAIN_ERR_EN
        ovf_d      = ovf_q;
`endif

        for (int c = 0; c < NUM_COL; c++) begin
            f = int'(col_filter_idx[c*2 +: 2]);
            if (f < NUM_FILT) begin
                eligible[c] = col_valid[c] && (cnt_q[c*NUM_FILT + f] < num_q);
`ifdef PSUM_DRAIN_ERR_EN
                if (state_q == DRAIN && col_valid[c] && cnt_q[c*NUM_FILT + f] == num_q)
                    ovf_d = 1'b1;
`endif
            end
        end

        for (int i = 0; i < NUM_COL; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_COL;
            if (!grant && eligible[idx]) begin
                grant     = 1'b1;
                grant_col = CW'(idx);
            end
        end

        for (int k = 0; k < NCNT; k++) begin
            if (cnt_q[k] != num_q) all_full = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_drain) begin
                    num_d = num_psum;
                    for (int k = 0; k < NCNT; k++) cnt_d[k] = '0;
                    state_d = (num_psum == 6'd0) ? DONE : DRAIN;
`ifdef PSUM_DRAIN_ERR_EN
                    ovf_d = 1'b0;
`endif
                end
            end
            DRAIN: begin
                if (slot_free && grant) begin
                    gi = int'(grant_col);
                    gf = int'(col_filter_idx[gi*2 +: 2]);
                    col_ack[grant_col] = 1'b1;
                    wr_valid_d = 1'b1;
                    wr_data_d  = col_psum[gi*PSUM_W +: PSUM_W];
                    wr_addr_d  = 11'(gf*NUM_COL*DEPTH + gi*DEPTH + int'(cnt_q[gi*NUM_FILT + gf]));
                    cnt_d[gi*NUM_FILT + gf] = cnt_q[gi*NUM_FILT + gf] + 6'd1;
                    rr_ptr_d = (gi == NUM_COL - 1) ? '0 : CW'(gi + 1);
                end else if (wr_valid_q && wr_ready) begin
                    wr_valid_d = 1'b0;
                end
                // Only finish once the last accepted psum has left the output slot.
                if (all_full && !wr_valid_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            num_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
`ifdef PSUM_DRAIN_ERR_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            num_q      <= num_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
`ifdef PSUM_DRAIN_ERR_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;
`ifdef PSUM_DRAIN_ERR_EN
    assign overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_psum_drain_arbiter.sv
// Testbench for psum_drain_arbiter: directed scenarios plus randomized drains checked
// against a transaction-level reference model and an expected-write queue.
`ifndef PSUM_DATA_SIZE
`define PSUM_DATA_SIZE 16
`endif

module tb_psum_drain_arbiter;

    localparam int NC = 7;
    localparam int NF = 4;
    localparam int DP = 55;
    localparam int DW = `PSUM_DATA_SIZE;
    localparam int QW = 11 + DW;
    localparam int S_IDLE  = 0;
    localparam int S_DRAIN = 1;
    localparam int S_DONE  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start_drain = 1'b0;
    logic [5:0]        num_psum = '0;
    logic [NC-1:0]     col_valid = '0;
    logic [NC*2-1:0]   col_filter_idx = '0;
    logic [NC*DW-1:0]  col_psum = '0;
    logic              wr_ready = 1'b0;
    logic [NC-1:0]     col_ack;
    logic              wr_valid;
    logic [10:0]       wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;
`ifdef PSUM_DRAIN_ERR_EN
    logic              overflow_err;
`endif

    psum_drain_arbiter #(.NUM_COL(NC), .NUM_FILT(NF), .DEPTH(DP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_drain(start_drain),
        .num_psum(num_psum),
        .col_valid(col_valid),
        .col_filter_idx(col_filter_idx),
        .col_psum(col_psum),
        .col_ack(col_ack),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .dbg_state(dbg_state)
`ifdef PSUM_DRAIN_ERR_EN
        ,
        .overflow_err(overflow_err)
`endif
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model and scoreboard
    int              m_phase;
    int              m_num;
    int              m_rr;
    int              m_cnt [NC][NF];
    bit              m_ovf;
    logic [QW-1:0]   exp_q [$];
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = S_IDLE;
        m_num   = 0;
        m_rr    = 0;
        m_ovf   = 1'b0;
        foreach (m_cnt[c, f]) m_cnt[c][f] = 0;
        exp_q.delete();
    endtask

    // Column that should be granted this cycle, or -1.
    function automatic int model_pick();
        if (m_phase != S_DRAIN) return -1;
        if (exp_q.size() != 0 && !wr_ready) return -1;
        for (int i = 0; i < NC; i++) begin
            int c = (m_rr + i) % NC;
            int f = int'(col_filter_idx[2*c +: 2]);
            if (col_valid[c] && m_cnt[c][f] < m_num) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        logic [NC-1:0] exp_ack;
        g = model_pick();
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        check("col_ack", col_ack, exp_ack);
        check("busy", busy, m_phase == S_DRAIN);
        check("done", done, m_phase == S_DONE);
        check("dbg_state", dbg_state, m_phase);
        check("wr_valid", wr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("wr_addr_data", {wr_addr, wr_data}, exp_q[0]);
`ifdef PSUM_DRAIN_ERR_EN
        check("overflow_err", overflow_err, m_ovf);
`endif
    endtask

    task automatic model_update();
        int g;
        int f;
        bit full;
        g = model_pick();
        case (m_phase)
            S_IDLE: begin
                if (start_drain) begin
                    foreach (m_cnt[c, k]) m_cnt[c][k] = 0;
                    m_num   = int'(num_psum);
                    m_ovf   = 1'b0;
                    m_phase = (num_psum == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                full = (exp_q.size() == 0);
                foreach (m_cnt[c, k]) if (m_cnt[c][k] != m_num) full = 1'b0;
                for (int c = 0; c < NC; c++) begin
                    f = int'(col_filter_idx[2*c +: 2]);
                    if (col_valid[c] && m_cnt[c][f] == m_num) m_ovf = 1'b1;
                end
                if (exp_q.size() != 0 && wr_ready) void'(exp_q.pop_front());
                if (g >= 0) begin
                    f = int'(col_filter_idx[2*g +: 2]);
                    exp_q.push_back({11'(f*NC*DP + g*DP + m_cnt[g][f]), col_psum[g*DW +: DW]});
                    m_cnt[g][f]++;
                    m_rr = (g + 1) % NC;
                end
                if (full) m_phase = S_DONE;
            end
            default: m_phase = S_IDLE;
        endcase
    endtask

    // Driver tasks: inputs change at posedge+1, outputs checked at negedge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_all(input logic [NC-1:0] v, input int filt);
        col_valid = v;
        for (int c = 0; c < NC; c++) begin
            col_filter_idx[2*c +: 2] = 2'(filt);
            col_psum[c*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic start(input int n);
        num_psum = 6'(n);
        start_drain = 1'b1;
        step();
        start_drain = 1'b0;
    endtask

    task automatic randomize_inputs(input bit over);
        int open [$];
        int f;
        for (int c = 0; c < NC; c++) begin
            open.delete();
            for (int k = 0; k < NF; k++) if (m_cnt[c][k] < m_num) open.push_back(k);
            if (open.size() == 0 || (over && $urandom_range(0, 7) == 0))
                f = $urandom_range(0, NF - 1);
            else
                f = open[$urandom_range(0, open.size() - 1)];
            col_valid[c] = ($urandom_range(0, 3) != 0);
            col_filter_idx[2*c +: 2] = 2'(f);
            col_psum[c*DW +: DW] = DW'($urandom);
        end
        wr_ready    = ($urandom_range(0, 3) != 0);
        start_drain = ($urandom_range(0, 15) == 0);
        num_psum    = 6'($urandom_range(0, 63));
    endtask

    task automatic drain_random(input int budget, input bit over);
        int n = 0;
        while (m_phase != S_IDLE && n < budget) begin
            randomize_inputs(over);
            step();
            n++;
        end
        check("drain_completed", n < budget, 1'b1);
        start_drain = 1'b0;
        col_valid   = '0;
        wr_ready    = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_col_ack"}, col_ack, '0);
        check({tag, "_wr_valid"}, wr_valid, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, '0);
        check({tag, "_wr_data"}, wr_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
`ifdef PSUM_DRAIN_ERR_EN
        check({tag, "_overflow_err"}, overflow_err, 1'b0);
`endif
    endtask

    // Stimulus
    initial begin
        logic [QW-1:0] held;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_ready = 1'b1;
        step();
        step();

        // Single psum per column on filter 0: round-robin from col0 after reset.
        set_all('1, 0);
        wr_ready = 1'b1;
        start(1);
        for (int k = 0; k < NC; k++) begin
            step();
            check("seq_addr", wr_addr, 11'(k * DP));
        end
        drain_random(3000, 1'b0);

        // Output stall: nothing granted, write held while wr_ready is low.
        set_all('1, 0);
        wr_ready = 1'b1;
        start(2);
        step();
        held = exp_q[0];
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_ack", col_ack, '0);
            check("stall_hold", {wr_addr, wr_data}, held);
        end
        drain_random(3000, 1'b0);

        // Only col3 valid on filter 2.
        set_all(7'b0001000, 2);
        wr_ready = 1'b1;
        start(3);
        for (int k = 0; k < 3; k++) begin
            step();
            check("col3_addr", wr_addr, 11'(935 + k));
        end
        drain_random(3000, 1'b0);

        // Zero-length drain goes straight to DONE.
        set_all('1, 1);
        start(0);
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_ack", col_ack, '0);
        step();
        check("zero_done_clear", done, 1'b0);
        step();

        // Reset in the middle of a drain with a write pending.
        set_all('1, 0);
        wr_ready = 1'b1;
        start(4);
        step();
        wr_ready = 1'b0;
        step();
        check("mid_pre_valid", wr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        col_valid = '0;
        wr_ready  = 1'b1;
        step();
        step();
        check("post_reset_busy", busy, 1'b0);
        set_all('1, 0);
        start(2);
        drain_random(3000, 1'b1);

        // col0 offers a 4th psum for filter 1 when only 3 are expected.
        set_all(7'b0000001, 1);
        wr_ready = 1'b1;
        start(3);
        for (int k = 0; k < 3; k++) step();
        step();
        check("over_ack", col_ack, '0);
`ifdef PSUM_DRAIN_ERR_EN
        check("over_err", overflow_err, 1'b1);
`endif
        drain_random(3000, 1'b1);

        // Randomized drains.
        for (int r = 0; r < 6; r++) begin
            randomize_inputs(1'b1);
            start($urandom_range(1, 5));
            drain_random(3000, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
